data_memory_responder: RTL

- Slave end of the data-memory interface driven by the memory-access pipeline stage.
- Accepts one load or store request at a time and holds it in an on-chip word-organised data RAM.
- Applies a programmable number of wait states, then returns a single-cycle response: read data, or store acknowledge plus fault flag.
- Sits between the memory-access stage and the writeback stage; the pipeline stalls on req_ready low.

---
 rtl/data_memory_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// Slave end of the data-memory interface: one outstanding load/store, programmable
// wait states, single-cycle response with fault flag.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a request; acceptance captures all request fields
// ST_WAIT | counting down wait states on the captured request
// ST_RESP | response strobe; stores commit on the edge that leaves here
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_address,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_fault,
  output logic        busy
);

  localparam int          IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_STATES);
  localparam logic [15:0] DEPTH_LIMIT = 16'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_cnt_nxt;
  logic              hold_write;
  logic              hold_byte;
  logic [15:0]       hold_address;
  logic [15:0]       hold_wdata;
  logic [15:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic              commit;
  logic [IDX_W-1:0]  word_idx;
  logic [15:0]       rd_word;
  logic [15:0]       load_data;

  assign req_ready = (state == ST_IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;

  // Faults are judged on the captured request, so they stay stable through RESP.
  assign misaligned   = !hold_byte && hold_address[0];
  assign out_of_range = ({1'b0, hold_address[15:1]} >= DEPTH_LIMIT);
  assign fault        = misaligned || out_of_range;

  assign word_idx  = hold_address[IDX_W:1];
  assign rd_word   = mem[word_idx];
  assign load_data = hold_byte ? {8'h00, (hold_address[0] ? rd_word[15:8] : rd_word[7:0])}
                               : rd_word;

  assign resp_valid = (state == ST_RESP);
  assign resp_fault = resp_valid && fault;
  assign resp_rdata = (resp_valid && !fault && !hold_write) ? load_data : 16'h0000;
  assign commit     = resp_valid && hold_write && !fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wait_cnt     <= 4'd0;
      hold_write   <= 1'b0;
      hold_byte    <= 1'b0;
      hold_address <= 16'h0000;
      hold_wdata   <= 16'h0000;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        hold_write   <= req_write;
        hold_byte    <= req_byte;
        hold_address <= req_address;
        hold_wdata   <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_INIT != 4'd0) begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WAIT_INIT;
          end else begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) begin
          state_nxt    = ST_RESP;
          wait_cnt_nxt = 4'd0;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  // RAM is never reset; a reset on the closing edge of RESP cancels the store.
  always_ff @(posedge clk) begin
    if (rst_n && commit) begin
      if (!hold_byte) begin
        mem[word_idx] <= hold_wdata;
      end else if (hold_address[0]) begin
        mem[word_idx][15:8] <= hold_wdata[7:0];
      end else begin
        mem[word_idx][7:0] <= hold_wdata[7:0];
      end
    end
  end

endmodule
